// File: rtl/spw_pkg.sv
// Shared encodings for the SpaceWire receiver: control codes, N-char values,
// the NULL alignment pattern and the receiver FSM states.
package spw_pkg;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_RUN  = 1'b1
    } rx_state_e;

    // Two control bits packed as {first_received, second_received}.
    typedef enum logic [1:0] {
        CTL_FCT = 2'b00,
        CTL_EEP = 2'b01,
        CTL_EOP = 2'b10,
        CTL_ESC = 2'b11
    } ctl_code_e;

    localparam logic [8:0] RX_EOP = 9'h100;
    localparam logic [8:0] RX_EEP = 9'h101;

    // ESC then FCT, first-received bit in the MSB.
    localparam logic [7:0] NULL_PATTERN = 8'b0111_0100;

endpackage

// File: rtl/spw_rx_sync.sv
// Brings rx_d/rx_s into the clk domain and strobes once per D/S transition,
// presenting the synchronized data level as the recovered bit.
module spw_rx_sync #(
    parameter int SYNC_STAGES = 2   // minimum 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_d,
    input  logic rx_s,
    output logic bit_stb,
    output logic bit_val
);

    logic [SYNC_STAGES-1:0] d_pipe;
    logic [SYNC_STAGES-1:0] s_pipe;
    logic                   x_q;
    logic                   x_now;

    assign x_now   = d_pipe[SYNC_STAGES-1] ^ s_pipe[SYNC_STAGES-1];
    assign bit_stb = x_now ^ x_q;
    assign bit_val = d_pipe[SYNC_STAGES-1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_pipe <= '0;
            s_pipe <= '0;
            x_q    <= 1'b0;
        end else begin
            d_pipe <= {d_pipe[SYNC_STAGES-2:0], rx_d};
            s_pipe <= {s_pipe[SYNC_STAGES-2:0], rx_s};
            x_q    <= x_now;
        end
    end

endmodule

// File: rtl/spw_rx.sv
// SpaceWire Data-Strobe receiver: bit recovery, NULL acquisition, character
// decoding with parity/escape checking and disconnect detection.
module spw_rx
    import spw_pkg::*;
#(
    parameter int DISC_CYCLES = 43,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_en,
    input  logic       rx_d,
    input  logic       rx_s,
    output logic [8:0] rx_data,
    output logic       rx_valid,
    output logic       got_null,
    output logic       got_fct,
    output logic       tick_out,
    output logic [7:0] time_out,
    output logic       err_par,
    output logic       err_esc,
    output logic       err_disc
);

    localparam int DISC_W = $clog2(DISC_CYCLES + 1);

    logic bit_stb;
    logic bit_val;

    spw_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .rx_d    (rx_d),
        .rx_s    (rx_s),
        .bit_stb (bit_stb),
        .bit_val (bit_val)
    );

    rx_state_e   state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  win_q, win_d, win_nxt;
    logic [7:0]  data_q, data_d, data_nxt;
    logic        p_q, p_d, f_q, f_d;
    logic        prev_par_q, prev_par_d;
    logic        esc_q, esc_d;
    logic [DISC_W-1:0] disc_cnt_q, disc_cnt_d;
    logic        disc_arm_q, disc_arm_d;
    logic        got_null_q, got_null_d;
    logic [8:0]  rx_data_q, rx_data_d;
    logic [7:0]  time_q, time_d;
    logic        rx_valid_q, rx_valid_d, got_fct_q, got_fct_d, tick_q, tick_d;
    logic        err_par_q, err_par_d, err_esc_q, err_esc_d, err_disc_q, err_disc_d;
    logic        char_end, error;
    ctl_code_e   ctl;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_HUNT;
            bit_cnt_q  <= '0;
            win_q      <= '0;
            data_q     <= '0;
            p_q        <= 1'b0;
            f_q        <= 1'b0;
            prev_par_q <= 1'b0;
            esc_q      <= 1'b0;
            disc_cnt_q <= '0;
            disc_arm_q <= 1'b0;
            got_null_q <= 1'b0;
            rx_data_q  <= '0;
            time_q     <= '0;
            rx_valid_q <= 1'b0;
            got_fct_q  <= 1'b0;
            tick_q     <= 1'b0;
            err_par_q  <= 1'b0;
            err_esc_q  <= 1'b0;
            err_disc_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            win_q      <= win_d;
            data_q     <= data_d;
            p_q        <= p_d;
            f_q        <= f_d;
            prev_par_q <= prev_par_d;
            esc_q      <= esc_d;
            disc_cnt_q <= disc_cnt_d;
            disc_arm_q <= disc_arm_d;
            got_null_q <= got_null_d;
            rx_data_q  <= rx_data_d;
            time_q     <= time_d;
            rx_valid_q <= rx_valid_d;
            got_fct_q  <= got_fct_d;
            tick_q     <= tick_d;
            err_par_q  <= err_par_d;
            err_esc_q  <= err_esc_d;
            err_disc_q <= err_disc_d;
        end
    end

    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        win_d      = win_q;
        data_d     = data_q;
        p_d        = p_q;
        f_d        = f_q;
        prev_par_d = prev_par_q;
        esc_d      = esc_q;
        disc_cnt_d = disc_cnt_q;
        disc_arm_d = disc_arm_q;
        got_null_d = got_null_q;
        rx_data_d  = rx_data_q;
        time_d     = time_q;
        rx_valid_d = 1'b0;
        got_fct_d  = 1'b0;
        tick_d     = 1'b0;
        err_par_d  = 1'b0;
        err_esc_d  = 1'b0;
        err_disc_d = 1'b0;
        error      = 1'b0;
        data_nxt   = {bit_val, data_q[7:1]};
        win_nxt    = {win_q[6:0], bit_val};
        ctl        = ctl_code_e'({data_nxt[6], data_nxt[7]});
        char_end   = bit_stb && (state_q == ST_RUN) &&
                     (f_q ? (bit_cnt_q == 4'd3) : (bit_cnt_q == 4'd9));

        // Disconnect timer restarts on every bit; armed by the first bit seen.
        if (bit_stb) begin
            disc_cnt_d = '0;
            disc_arm_d = 1'b1;
        end else if (disc_arm_q) begin
            disc_cnt_d = disc_cnt_q + 1'b1;
            if (disc_cnt_q == DISC_W'(DISC_CYCLES - 1)) begin
                err_disc_d = 1'b1;
                error      = 1'b1;
            end
        end

        case (state_q)
            ST_HUNT: begin
                if (bit_stb) begin
                    win_d = win_nxt;
                    if (bit_cnt_q != 4'd7) bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7 && win_nxt == NULL_PATTERN) begin
                        // Aligned right after the FCT half of a NULL (control bits 00).
                        state_d    = ST_RUN;
                        got_null_d = 1'b1;
                        bit_cnt_d  = '0;
                        prev_par_d = 1'b0;
                        esc_d      = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (bit_stb) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd0)      p_d = bit_val;
                    else if (bit_cnt_q == 4'd1) f_d = bit_val;
                    else                        data_d = data_nxt;
                end
                if (char_end) begin
                    bit_cnt_d = '0;
                    if (!(prev_par_q ^ p_q ^ f_q)) begin
                        err_par_d = 1'b1;
                        error     = 1'b1;
                    end else if (f_q) begin
                        prev_par_d = data_nxt[6] ^ data_nxt[7];
                        if (esc_q) begin
                            esc_d = 1'b0;
                            if (ctl != CTL_FCT) begin
                                err_esc_d = 1'b1;
                                error     = 1'b1;
                            end
                        end else begin
                            case (ctl)
                                CTL_FCT: got_fct_d = 1'b1;
                                CTL_EOP: begin rx_valid_d = 1'b1; rx_data_d = RX_EOP; end
                                CTL_EEP: begin rx_valid_d = 1'b1; rx_data_d = RX_EEP; end
                                default: esc_d = 1'b1;
                            endcase
                        end
                    end else begin
                        prev_par_d = ^data_nxt;
                        if (esc_q) begin
                            esc_d  = 1'b0;
                            tick_d = 1'b1;
                            time_d = data_nxt;
                        end else begin
                            rx_valid_d = 1'b1;
                            rx_data_d  = {1'b0, data_nxt};
                        end
                    end
                end
            end
            default: state_d = ST_HUNT;
        endcase

        if (error || !rx_en) begin
            state_d    = ST_HUNT;
            got_null_d = 1'b0;
            esc_d      = 1'b0;
            prev_par_d = 1'b0;
            bit_cnt_d  = '0;
            win_d      = '0;
            disc_cnt_d = '0;
            disc_arm_d = 1'b0;
        end
        // Disabling the receiver silently drops whatever was in flight.
        if (!rx_en) begin
            rx_valid_d = 1'b0;
            got_fct_d  = 1'b0;
            tick_d     = 1'b0;
            err_par_d  = 1'b0;
            err_esc_d  = 1'b0;
            err_disc_d = 1'b0;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign got_null = got_null_q;
    assign got_fct  = got_fct_q;
    assign tick_out = tick_q;
    assign time_out = time_q;
    assign err_par  = err_par_q;
    assign err_esc  = err_esc_q;
    assign err_disc = err_disc_q;

endmodule

// File: doc/spw_rx.md
SPW_RX -- requirements
Module: spw_rx

Interface
REQ-001 SHALL have parameter DISC_CYCLES, default 43, clk cycles without a D/S transition before disconnect (~850 ns at 50 MHz).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, depth of the rx_d/rx_s input synchronizer.
REQ-003 SHALL have port clk  input  1  single system clock (50 MHz nominal).
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port rx_en  input  1  receiver enable from link FSM; low forces HUNT.
REQ-006 SHALL have ports rx_d, rx_s  input  1 each  Data-Strobe serial line, asynchronous to clk.
REQ-007 SHALL have port rx_data  output  9  received N-char: bit8=0 data byte, 9'h100 EOP, 9'h101 EEP.
REQ-008 SHALL have port rx_valid  output  1  one-cycle strobe qualifying rx_data.
REQ-009 SHALL have ports got_null, got_fct  output  1 each  got_null level (latched), got_fct one-cycle strobe.
REQ-010 SHALL have ports tick_out  output  1, time_out  output  8  time-code strobe and value.
REQ-011 SHALL have ports err_par, err_esc, err_disc  output  1 each  one-cycle error strobes.

Function
REQ-012 SHALL recover bits by sampling synchronized rx_d on each change of (rx_d XOR rx_s); both edges of the recovered clock carry data.
REQ-013 SHALL decode characters in arrival order: P, F, then 8 data bits LSB-first (F=0) or 2 control bits (F=1): FCT=00, EOP=10, EEP=01, ESC=11 (bits listed first-received first).
REQ-014 SHALL check odd parity over current P, current F, and the data/control bits of the preceding character; mismatch pulses err_par.
REQ-015 SHALL implement FSM HUNT -> RUN; reset and rx_en=0 give HUNT.
REQ-016 In HUNT SHALL compare a sliding 8-bit window against NULL pattern 0,1,1,1,0,1,0,0 (first-received first) bit by bit; match sets got_null, aligns character boundary, enters RUN; no other output asserts in HUNT.
REQ-017 In RUN SHALL decode aligned characters: data -> rx_valid with {1'b0,byte}; EOP/EEP -> rx_valid with 9'h100/9'h101; FCT -> got_fct; ESC sets escape flag.
REQ-018 With escape flag set: FCT -> NULL (no strobe), data char -> tick_out with time_out=byte, ESC/EOP/EEP -> err_esc; flag clears after the following character.
REQ-019 rx_valid, got_fct, tick_out SHALL assert exactly one clk cycle, 1 cycle after the cycle the character's last bit is sampled; no back-pressure.
REQ-020 Disconnect counter SHALL reset on every sampled bit and count in RUN and while in HUNT after the first bit; reaching DISC_CYCLES pulses err_disc.
REQ-021 Any error (err_par, err_esc, err_disc) SHALL clear got_null, escape flag, parity history and return to HUNT the next cycle; errors are strobed once per event.
REQ-022 rx_en falling mid-character SHALL discard the partial character without strobes or errors.
REQ-023 Simultaneous ESC error and parity error on the same character SHALL report err_par only.

Reset
REQ-024 On rst low all outputs SHALL be 0 (rx_data 9'h000, time_out 8'h00), FSM HUNT, counters, shift register, parity history and synchronizer cleared; release is synchronous to clk via the synchronizer.

Structure
REQ-025 Shared package spw_pkg SHALL hold control-code encodings, EOP/EEP 9-bit values, NULL pattern, and FSM state enum.
REQ-026 Synchronizer and transition detector SHALL be sub-module spw_rx_sync (SYNC_STAGES flops on rx_d/rx_s, bit-strobe output).

Verification
REQ-027 Serial NULLs at 10 Mb/s after reset -> got_null=1 after first NULL; no rx_valid, no errors.
REQ-028 NULL, then data 0xA5, then EOP -> rx_valid twice, rx_data 9'h0A5 then 9'h100.
REQ-029 NULL, FCT, ESC+0x3F -> got_fct one pulse; tick_out one pulse with time_out=8'h3F; no rx_valid.
REQ-030 NULL, data 0x55 with parity bit inverted -> err_par one pulse, got_null=0, next NULL re-acquires.
REQ-031 NULL then line frozen for DISC_CYCLES+2 cycles -> err_disc one pulse, got_null=0; ESC,ESC -> err_esc.
REQ-032 rst asserted mid data character -> all outputs 0 immediately; after release, NULL, 0x12 -> rx_data 9'h012.
